// File: rtl/kwan_ctr_pkg.sv
// Types shared by the kwan counter family (this down timer and the up-counter wrappers).
package kwan_ctr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } ctr_state_t;

endpackage

// File: rtl/sn74x_down_timer.sv
// Synchronous N-bit down counter with parallel load, reload register and terminal-count borrow.
// Cascade wide timers by wiring bo of the lower stage into t of the upper stage.
module sn74x_down_timer
   import kwan_ctr_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         load,
   input  logic [N-1:0] d,
   input  logic         p,
   input  logic         t,
   input  logic         autorel,
   output logic [N-1:0] q,
   output logic         bo,
   output logic         tick,
   output logic         busy
);

   logic [N-1:0] r_q;
   logic [N-1:0] r_rld;
   ctr_state_t   r_st;
   logic         r_tick;

   logic [N-1:0] w_q_nxt;
   logic [N-1:0] w_rld_nxt;
   ctr_state_t   w_st_nxt;
   logic         w_tick_nxt;
   logic         w_en;
   logic         w_zero;

   assign w_en   = p & t;
   assign w_zero = (r_q == {N{1'b0}});

   // Next-state: load beats counting; the terminal edge is the enabled edge seen while q==0.
   always_comb begin
      w_q_nxt    = r_q;
      w_rld_nxt  = r_rld;
      w_st_nxt   = r_st;
      w_tick_nxt = 1'b0;
      if (load) begin
         w_q_nxt   = d;
         w_rld_nxt = d;
         w_st_nxt  = ST_RUN;
      end else begin
         case (r_st)
            ST_RUN: begin
               if (w_en) begin
                  if (!w_zero) begin
                     w_q_nxt = r_q - N'(1);
                  end else begin
                     w_tick_nxt = 1'b1;
                     if (autorel) begin
                        w_q_nxt = r_rld;
                     end else begin
                        w_st_nxt = ST_DONE;
                     end
                  end
               end else begin
                  w_q_nxt = r_q;
               end
            end
            ST_IDLE: w_st_nxt = ST_IDLE;
            ST_DONE: w_st_nxt = ST_DONE;
            default: w_st_nxt = ST_IDLE;
         endcase
      end
   end

   // State register with synchronous clear dominating everything else.
   always_ff @(posedge clk) begin
      if (clr) begin
         r_q    <= {N{1'b0}};
         r_rld  <= {N{1'b0}};
         r_st   <= ST_IDLE;
         r_tick <= 1'b0;
      end else begin
         r_q    <= w_q_nxt;
         r_rld  <= w_rld_nxt;
         r_st   <= w_st_nxt;
         r_tick <= w_tick_nxt;
      end
   end

   assign q    = r_q;
   assign tick = r_tick;
   assign busy = (r_st == ST_RUN);
   assign bo   = t & w_zero & (r_st == ST_RUN);

endmodule

// File: tb/tb_sn74x_down_timer.sv
// Scoreboard bench for sn74x_down_timer: a single unit plus a two-stage cascade.
module tb_sn74x_down_timer;

   typedef struct {
      logic [15:0] exp;
      logic [15:0] mask;
      string       name;
   } sb_item_t;

   logic       clk = 1'b0;
   logic       clr, load, p, t, autorel;
   logic [3:0] d;
   logic [3:0] q;
   logic       bo, tick, busy;

   logic       c_load, c_en, c_arl;
   logic [3:0] c_dlo, c_dhi;
   logic [3:0] lo_q, hi_q;
   logic       lo_bo, hi_bo, lo_tick, hi_tick, lo_busy, hi_busy;

   sb_item_t   sb[$];
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   sn74x_down_timer #(.N(4)) dut (
      .clk(clk), .clr(clr), .load(load), .d(d), .p(p), .t(t), .autorel(autorel),
      .q(q), .bo(bo), .tick(tick), .busy(busy)
   );

   sn74x_down_timer #(.N(4)) u_lo (
      .clk(clk), .clr(clr), .load(c_load), .d(c_dlo), .p(c_en), .t(1'b1), .autorel(c_arl),
      .q(lo_q), .bo(lo_bo), .tick(lo_tick), .busy(lo_busy)
   );

   sn74x_down_timer #(.N(4)) u_hi (
      .clk(clk), .clr(clr), .load(c_load), .d(c_dhi), .p(c_en), .t(lo_bo), .autorel(1'b0),
      .q(hi_q), .bo(hi_bo), .tick(hi_tick), .busy(hi_busy)
   );

   // Monitor: each clock the DUT presents a new registered result; compare it with the oldest expectation.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            sb_item_t   it;
            logic [15:0] act;
            it  = sb.pop_front();
            act = {q, tick, busy, bo, lo_bo, hi_q, lo_q};
            checks++;
            if ((act & it.mask) !== (it.exp & it.mask)) begin
               errors++;
               $display("FAIL %s: got %h required %h (mask %h)", it.name, act & it.mask,
                        it.exp & it.mask, it.mask);
            end
         end
      end
   end

   task automatic step_m(input logic c, input logic l, input logic [3:0] dv, input logic pv,
                         input logic tv, input logic ar, input logic [3:0] eq, input logic et,
                         input logic eb, input logic ebo, input string nm);
      sb_item_t it;
      @(negedge clk);
      clr = c; load = l; d = dv; p = pv; t = tv; autorel = ar;
      c_load = 1'b0; c_en = 1'b0;
      it.exp  = {eq, et, eb, ebo, 1'b0, 8'h00};
      it.mask = 16'hFE00;
      it.name = nm;
      sb.push_back(it);
   endtask

   task automatic step_c(input logic l, input logic en, input logic [3:0] eh,
                         input logic [3:0] el, input logic elbo, input string nm);
      sb_item_t it;
      @(negedge clk);
      clr = 1'b0; load = 1'b0; p = 1'b0; t = 1'b0;
      c_load = l; c_en = en;
      it.exp  = {7'h00, elbo, eh, el};
      it.mask = 16'h01FF;
      it.name = nm;
      sb.push_back(it);
   endtask

   initial begin
      clr = 1'b1; load = 1'b0; d = 4'h0; p = 1'b0; t = 1'b0; autorel = 1'b0;
      c_load = 1'b0; c_en = 1'b0; c_arl = 1'b1; c_dlo = 4'h2; c_dhi = 4'h1;

      // reset, then enables alone must not start an idle counter
      step_m(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, "reset");
      for (int i = 0; i < 4; i++)
         step_m(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, "idle_hold");

      // one-shot from 3
      step_m(1'b0, 1'b1, 4'h3, 1'b1, 1'b1, 1'b0, 4'h3, 1'b0, 1'b1, 1'b0, "os_load");
      step_m(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h2, 1'b0, 1'b1, 1'b0, "os_2");
      step_m(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h1, 1'b0, 1'b1, 1'b0, "os_1");
      step_m(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, "os_0");
      step_m(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, "os_term");
      step_m(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, "os_done");

      // auto-reload from 2: 2,1,0,2,1,0,2
      step_m(1'b0, 1'b1, 4'h2, 1'b1, 1'b1, 1'b1, 4'h2, 1'b0, 1'b1, 1'b0, "ar_load");
      step_m(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0, "ar_1a");
      step_m(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, "ar_0a");
      step_m(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h2, 1'b1, 1'b1, 1'b0, "ar_rel_a");
      step_m(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0, "ar_1b");
      step_m(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, "ar_0b");
      step_m(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h2, 1'b1, 1'b1, 1'b0, "ar_rel_b");

      // enable gating: p low, then t low, hold at 1; t low also masks bo at zero
      step_m(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0, "en_to1");
      for (int i = 0; i < 3; i++)
         step_m(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0, "p_low_hold");
      for (int i = 0; i < 2; i++)
         step_m(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0, "t_low_hold");
      step_m(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, "en_to0");
      step_m(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, "t_low_bo");
      step_m(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h2, 1'b1, 1'b1, 1'b0, "en_term");

      // load beats terminal count; clr beats load
      step_m(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0, "pri_to1");
      step_m(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, "pri_to0");
      step_m(1'b0, 1'b1, 4'h5, 1'b1, 1'b1, 1'b1, 4'h5, 1'b0, 1'b1, 1'b0, "load_vs_term");
      step_m(1'b1, 1'b1, 4'h7, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, "clr_vs_load");

      // zero reload value with auto-reload ticks every enabled cycle
      step_m(1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, "rld0_load");
      step_m(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b1, 1'b1, 1'b1, "rld0_tick_a");
      step_m(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b1, 1'b1, 1'b1, "rld0_tick_b");

      // clear mid-count, then the counter stays idle
      step_m(1'b0, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, "mid_load");
      step_m(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'hE, 1'b0, 1'b1, 1'b0, "mid_dec");
      step_m(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, "mid_clr");
      step_m(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, "post_clr");

      // cascade: lo reloads from 2, hi (one-shot) steps only on edges where lo==0
      step_c(1'b1, 1'b1, 4'h1, 4'h2, 1'b0, "cas_load");
      step_c(1'b0, 1'b1, 4'h1, 4'h1, 1'b0, "cas_e1");
      step_c(1'b0, 1'b1, 4'h1, 4'h0, 1'b1, "cas_e2");
      step_c(1'b0, 1'b0, 4'h1, 4'h0, 1'b1, "cas_hold");
      step_c(1'b0, 1'b1, 4'h0, 4'h2, 1'b0, "cas_e3_borrow");
      step_c(1'b0, 1'b1, 4'h0, 4'h1, 1'b0, "cas_e4");
      step_c(1'b0, 1'b1, 4'h0, 4'h0, 1'b1, "cas_e5");
      step_c(1'b0, 1'b1, 4'h0, 4'h2, 1'b0, "cas_e6_hi_term");
      step_c(1'b0, 1'b1, 4'h0, 4'h1, 1'b0, "cas_e7");

      @(negedge clk);
      c_en = 1'b0;
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
